// File: rtl/iq_width_downconv.sv
// IQ width down-converter: buffers wide real/imag word pairs in a small FIFO and
// streams them out as RATIO narrow lanes with first/last markers.
module iq_width_downconv #(
    parameter int DIN_WIDTH  = 32,
    parameter int DOUT_WIDTH = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int LSB_FIRST  = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [DIN_WIDTH-1:0]          s_real,
    input  logic [DIN_WIDTH-1:0]          s_imag,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [DOUT_WIDTH-1:0]         m_real,
    output logic [DOUT_WIDTH-1:0]         m_imag,
    output logic                          m_first,
    output logic                          m_last,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int RATIO = DIN_WIDTH / DOUT_WIDTH;
    localparam int CNT_W = $clog2(RATIO);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] LAST_LANE  = CNT_W'(RATIO - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [LVL_W-1:0] LVL_ONE    = LVL_W'(1);
    localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(FIFO_DEPTH);

    if ((DIN_WIDTH % DOUT_WIDTH) != 0 || RATIO < 2) begin : g_bad_ratio
        $error("iq_width_downconv: DIN_WIDTH must be a multiple (>=2x) of DOUT_WIDTH");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("iq_width_downconv: FIFO_DEPTH must be a power of two >= 2");
    end

    logic [DIN_WIDTH-1:0]  mem_real [FIFO_DEPTH];
    logic [DIN_WIDTH-1:0]  mem_imag [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [LVL_W-1:0]      level;
    logic [CNT_W-1:0]      cnt;
    logic                  out_of_reset;

    logic                  fifo_empty;
    logic                  push;
    logic                  load;
    logic                  pop;
    logic [CNT_W-1:0]      lane_sel;
    logic [31:0]           lane_shift;
    logic [DOUT_WIDTH-1:0] lane_real;
    logic [DOUT_WIDTH-1:0] lane_imag;

    // s_ready looks only at the registered level, so a full FIFO stays closed
    // even on a cycle where the head word is being popped.
    assign fifo_empty = (level == '0);
    assign s_ready    = out_of_reset && (level != FULL_LEVEL);
    assign push       = s_valid && s_ready;
    assign load       = (!m_valid || m_ready) && !fifo_empty;
    assign pop        = load && (cnt == LAST_LANE);
    assign fifo_level = level;

    always_comb begin
        lane_sel   = (LSB_FIRST != 0) ? cnt : (LAST_LANE - cnt);
        lane_shift = 32'(lane_sel) * 32'(DOUT_WIDTH);
        lane_real  = DOUT_WIDTH'(mem_real[rd_ptr] >> lane_shift);
        lane_imag  = DOUT_WIDTH'(mem_imag[rd_ptr] >> lane_shift);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_real[wr_ptr] <= s_real;
            mem_imag[wr_ptr] <= s_imag;
        end
    end

    // The head word stays in the FIFO until its last lane is loaded, so cnt can
    // only be non-zero while the FIFO holds at least one word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_of_reset <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            cnt          <= '0;
        end else begin
            out_of_reset <= 1'b1;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
            if (load) begin
                cnt <= pop ? '0 : (cnt + CNT_ONE);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_real  <= '0;
            m_imag  <= '0;
            m_first <= 1'b0;
            m_last  <= 1'b0;
        end else if (load) begin
            m_valid <= 1'b1;
            m_real  <= lane_real;
            m_imag  <= lane_imag;
            m_first <= (cnt == '0);
            m_last  <= (cnt == LAST_LANE);
        end else if (m_ready) begin
            m_valid <= 1'b0;
            m_real  <= '0;
            m_imag  <= '0;
            m_first <= 1'b0;
            m_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_iq_width_downconv.sv
// Bench for iq_width_downconv: three instances (32/16 LSB-first, 32/16 MS-first,
// 64/16 LSB-first) checked against a lane scoreboard plus directed timing checks.
module tb_iq_width_downconv;

    typedef logic [33:0] lane_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m_ready;
    logic [2:0]  s_valid_v;
    logic [63:0] s_real;
    logic [63:0] s_imag;

    logic        s_ready_a, m_valid_a, m_first_a, m_last_a;
    logic [15:0] m_real_a, m_imag_a;
    logic [2:0]  level_a;
    logic        s_ready_b, m_valid_b, m_first_b, m_last_b;
    logic [15:0] m_real_b, m_imag_b;
    logic [2:0]  level_b;
    logic        s_ready_c, m_valid_c, m_first_c, m_last_c;
    logic [15:0] m_real_c, m_imag_c;
    logic [2:0]  level_c;

    lane_t exp_q [3][$];
    int    lanes_seen [3];
    int    n_tests = 0;
    int    n_fail  = 0;

    always #5 clk = ~clk;

    iq_width_downconv #(.DIN_WIDTH(32), .DOUT_WIDTH(16), .FIFO_DEPTH(4), .LSB_FIRST(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid_v[0]), .s_ready(s_ready_a),
        .s_real(s_real[31:0]), .s_imag(s_imag[31:0]), .m_valid(m_valid_a), .m_ready(m_ready),
        .m_real(m_real_a), .m_imag(m_imag_a), .m_first(m_first_a), .m_last(m_last_a),
        .fifo_level(level_a)
    );

    iq_width_downconv #(.DIN_WIDTH(32), .DOUT_WIDTH(16), .FIFO_DEPTH(4), .LSB_FIRST(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid_v[1]), .s_ready(s_ready_b),
        .s_real(s_real[31:0]), .s_imag(s_imag[31:0]), .m_valid(m_valid_b), .m_ready(m_ready),
        .m_real(m_real_b), .m_imag(m_imag_b), .m_first(m_first_b), .m_last(m_last_b),
        .fifo_level(level_b)
    );

    iq_width_downconv #(.DIN_WIDTH(64), .DOUT_WIDTH(16), .FIFO_DEPTH(4), .LSB_FIRST(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid_v[2]), .s_ready(s_ready_c),
        .s_real(s_real), .s_imag(s_imag), .m_valid(m_valid_c), .m_ready(m_ready),
        .m_real(m_real_c), .m_imag(m_imag_c), .m_first(m_first_c), .m_last(m_last_c),
        .fifo_level(level_c)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Expected lanes of one word for instance d, built straight from the lane-order rules.
    task automatic pushWord(input int d, input logic [63:0] re, input logic [63:0] im);
        int ratio;
        int idx;
        ratio = (d == 2) ? 4 : 2;
        for (int k = 0; k < ratio; k++) begin
            idx = (d == 1) ? (ratio - 1 - k) : k;
            exp_q[d].push_back({re[idx*16 +: 16], im[idx*16 +: 16], (k == 0), (k == ratio - 1)});
        end
    endtask

    task automatic stepClk();
        @(posedge clk);
        #1;
    endtask

    // Offer one word to instance d; returns one step after the accepting edge.
    task automatic applyStimulus(input int d, input logic [63:0] re, input logic [63:0] im);
        int waited;
        logic rdy;
        s_real       = re;
        s_imag       = im;
        s_valid_v[d] = 1'b1;
        waited       = 0;
        @(negedge clk);
        rdy = (d == 0) ? s_ready_a : (d == 1) ? s_ready_b : s_ready_c;
        while (!rdy && waited < 200) begin
            @(negedge clk);
            waited++;
            rdy = (d == 0) ? s_ready_a : (d == 1) ? s_ready_b : s_ready_c;
        end
        if (!rdy) begin
            checkOutput("push_timeout", 64'(rdy), 64'd1);
        end else begin
            pushWord(d, re, im);
        end
        @(posedge clk);
        #1;
        s_valid_v[d] = 1'b0;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain_left", 64'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size()), 64'd0);
        @(negedge clk);
        checkOutput("drain_valid", {m_valid_a, m_valid_b, m_valid_c}, 64'd0);
        checkOutput("drain_data", {m_real_a, m_imag_a, m_first_a, m_last_a}, 64'd0);
    endtask

    // Scoreboard: every lane transferred on any instance is compared in order.
    always @(negedge clk) begin
        lane_t obs [3];
        logic [2:0] fire;
        lane_t e;
        obs[0] = {m_real_a, m_imag_a, m_first_a, m_last_a};
        obs[1] = {m_real_b, m_imag_b, m_first_b, m_last_b};
        obs[2] = {m_real_c, m_imag_c, m_first_c, m_last_c};
        fire   = {m_valid_c && m_ready, m_valid_b && m_ready, m_valid_a && m_ready};
        for (int d = 0; d < 3; d++) begin
            if (fire[d] === 1'b1) begin
                if (exp_q[d].size() == 0) begin
                    checkOutput($sformatf("unexpected_lane_%0d", d), 64'(exp_q[d].size()), 64'd1);
                end else begin
                    e = exp_q[d].pop_front();
                    checkOutput($sformatf("lane_%0d", d), 64'(obs[d]), 64'(e));
                    lanes_seen[d]++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int start_lanes;
        logic [31:0] bp_words [5];
        bp_words = '{32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 32'h7777_8888, 32'h9999_AAAA};
        for (int d = 0; d < 3; d++) lanes_seen[d] = 0;

        // Reset held with s_valid high
        rst_n     = 1'b0;
        m_ready   = 1'b1;
        s_valid_v = 3'b111;
        s_real    = 64'hDEAD_BEEF_AAAA_5555;
        s_imag    = 64'hCAFE_F00D_1234_5678;
        repeat (3) begin
            @(negedge clk);
            checkOutput("rst_valid", {m_valid_a, m_valid_b, m_valid_c}, 64'd0);
            checkOutput("rst_level", {level_a, level_b, level_c}, 64'd0);
            checkOutput("rst_ready", {s_ready_a, s_ready_b, s_ready_c}, 64'd0);
            checkOutput("rst_data", {m_real_a, m_imag_a, m_first_a, m_last_a}, 64'd0);
        end
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        s_valid_v = 3'b000;
        @(negedge clk);
        checkOutput("ready_before_clk", {s_ready_a, s_ready_b, s_ready_c}, 64'd0);
        @(negedge clk);
        checkOutput("ready_after_clk", {s_ready_a, s_ready_b, s_ready_c}, 64'b111);

        // Basic LSB-first word with one-edge latency check
        stepClk();
        s_real       = 64'h0000_0000_AAAA_5555;
        s_imag       = 64'h0000_0000_1234_5678;
        s_valid_v[0] = 1'b1;
        @(negedge clk);
        checkOutput("basic_ready", s_ready_a, 64'd1);
        pushWord(0, s_real, s_imag);
        @(posedge clk);
        #1;
        s_valid_v[0] = 1'b0;
        @(negedge clk);
        checkOutput("latency_e0_valid", m_valid_a, 64'd0);
        checkOutput("latency_e0_level", level_a, 64'd1);
        @(negedge clk);
        checkOutput("latency_e1_valid", m_valid_a, 64'd1);
        waitDrain();

        // MS-lane-first ordering
        stepClk();
        applyStimulus(1, 64'h0000_0000_AAAA_5555, 64'h0000_0000_1234_5678);
        waitDrain();

        // Backpressure: fill FIFO, fifth word must wait
        stepClk();
        m_ready     = 1'b0;
        start_lanes = lanes_seen[0];
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, {32'h0, bp_words[i]}, {32'h0, ~bp_words[i]});
        end
        s_real       = {32'h0, bp_words[4]};
        s_imag       = {32'h0, ~bp_words[4]};
        s_valid_v[0] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("full_ready", s_ready_a, 64'd0);
            checkOutput("full_level", level_a, 64'd4);
        end
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        applyStimulus(0, {32'h0, bp_words[4]}, {32'h0, ~bp_words[4]});
        waitDrain();
        checkOutput("bp_lane_count", 64'(lanes_seen[0] - start_lanes), 64'd10);

        // Stall after lane 0 is presented
        stepClk();
        m_ready = 1'b0;
        applyStimulus(0, 64'h0000_0000_BEEF_0123, 64'h0000_0000_4567_89AB);
        applyStimulus(0, 64'h0000_0000_F0F0_0F0F, 64'h0000_0000_3C3C_C3C3);
        repeat (4) begin
            @(negedge clk);
            checkOutput("stall_hold", {m_valid_a, m_real_a, m_imag_a, m_first_a, m_last_a},
                        {1'b1, 16'h0123, 16'h89AB, 1'b1, 1'b0});
            checkOutput("stall_level", level_a, 64'd2);
        end
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        @(negedge clk);
        checkOutput("stall_level_lane0", level_a, 64'd2);
        @(negedge clk);
        checkOutput("stall_level_lane1", level_a, 64'd1);
        waitDrain();

        // Reset with a partial word and queued words
        stepClk();
        m_ready = 1'b0;
        applyStimulus(0, 64'h0000_0000_0101_0202, 64'h0000_0000_0303_0404);
        applyStimulus(0, 64'h0000_0000_0505_0606, 64'h0000_0000_0707_0808);
        applyStimulus(0, 64'h0000_0000_0909_0A0A, 64'h0000_0000_0B0B_0C0C);
        @(negedge clk);
        checkOutput("pre_rst_level", level_a, 64'd3);
        checkOutput("pre_rst_valid", m_valid_a, 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) exp_q[d].delete();
        repeat (2) stepClk();
        @(negedge clk);
        checkOutput("mid_rst_clear", {m_valid_a, level_a, m_first_a, m_last_a, m_real_a}, 64'd0);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        m_ready = 1'b1;
        stepClk();
        applyStimulus(0, 64'h0000_0000_ABCD_EF01, 64'h0000_0000_2345_6789);
        waitDrain();

        // Four lanes per word on the 64/16 instance
        stepClk();
        applyStimulus(2, 64'h4444_3333_2222_1111, 64'h8888_7777_6666_5555);
        applyStimulus(2, 64'hFEDC_BA98_7654_3210, 64'h0F1E_2D3C_4B5A_6978);
        waitDrain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
